// File: rtl/mvm_tile_controller.sv
// rtl/mvm_tile_controller.sv - tile sequencer for the bit-serial MVM datapath
// Walks the tile row by row in CHANNELS-wide column groups and drives PE, selector and psum control.
module mvm_tile_controller #(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int CHANNELS = 4,
  parameter int LEN_W    = 8,
  localparam int GROUPS  = COLS / CHANNELS,
  localparam int GW      = (GROUPS > 1) ? $clog2(GROUPS) : 1,
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             pe_init,
  output logic             pe_enable,
  output logic             pe_reset,
  output logic             sel_reset,
  output logic             sel_enable,
  output logic             psum_clear,
  output logic             psum_enable,
  output logic [GW-1:0]    col_idx,
  output logic [RW-1:0]    row_idx,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [3:0] {
    IDLE, CLEAR, WAIT_IN, INIT, STREAM, ACCUM, OUTPUT, ADVANCE, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   counter_q, counter_d;
  logic [GW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic               aborted_q, aborted_d;
  logic               col_last, row_last;

  assign col_last = (col_q == GW'(GROUPS - 1));
  assign row_last = (row_q == RW'(ROWS - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      counter_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      counter_q <= counter_d;
      col_q     <= col_d;
      row_q     <= row_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    counter_d = counter_q;
    col_d     = col_q;
    row_d     = row_q;
    aborted_d = 1'b0;
    if (state_q != IDLE && abort) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = CLEAR;
            len_d   = cfg_len;
          end
        end
        CLEAR: begin
          col_d   = '0;
          row_d   = '0;
          state_d = WAIT_IN;
        end
        WAIT_IN: if (in_valid) state_d = INIT;
        INIT: begin
          counter_d = len_q;
          state_d   = STREAM;
        end
        STREAM: begin
          if (counter_q == '0) state_d = ACCUM;
          else counter_d = counter_q - LEN_W'(1);
        end
        ACCUM:  state_d = col_last ? OUTPUT : ADVANCE;
        OUTPUT: if (out_ready) state_d = ADVANCE;
        ADVANCE: begin
          if (col_last && row_last) begin
            state_d = DONE;
          end else begin
            if (col_last) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + GW'(1);
            end
            state_d = WAIT_IN;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    pe_init     = 1'b0;
    pe_enable   = 1'b0;
    pe_reset    = 1'b0;
    sel_reset   = 1'b0;
    sel_enable  = 1'b0;
    psum_clear  = 1'b0;
    psum_enable = 1'b0;
    done        = 1'b0;
    case (state_q)
      CLEAR:   pe_reset = 1'b1;
      WAIT_IN: in_ready = 1'b1;
      INIT: begin
        pe_init    = 1'b1;
        sel_reset  = 1'b1;
        // accumulator restarts only at the first group of each row
        psum_clear = (col_q == '0);
      end
      STREAM: begin
        pe_enable  = 1'b1;
        sel_enable = 1'b1;
      end
      ACCUM:   psum_enable = 1'b1;
      OUTPUT:  out_valid = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign aborted = aborted_q;
  assign col_idx = col_q;
  assign row_idx = row_q;

endmodule
